// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the system-side writer, the TX byte FIFO and the UART transmitter.
// The slave modport is the FIFO's view; the master modport drives writes and the transmitter busy flag.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 4
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic                  tx_busy;

  modport master (
    output wr_data, wr_en, flush, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_data_valid
  );

  modport slave (
    input  wr_data, wr_en, flush, tx_busy,
    output full, empty, count, overflow, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its data/valid/busy handshake.
// A byte leaves the FIFO only once the transmitter raises busy in response to the issue pulse.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  ack_wait_q, ack_wait_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic full;
  logic empty;
  logic pop;
  logic wr_accept;
  logic tx_data_valid;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // Issue FSM; ack_wait marks the second and last WAIT_ACK cycle before the byte counts as rejected.
  always_comb begin
    state_d       = state_q;
    ack_wait_d    = 1'b0;
    tx_data_d     = tx_data_q;
    tx_data_valid = 1'b0;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          state_d   = ISSUE;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      ISSUE: begin
        tx_data_valid = 1'b1;
        state_d       = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end else if (ack_wait_q) begin
          state_d = IDLE;
        end else begin
          ack_wait_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.flush) begin
      state_d       = IDLE;
      ack_wait_d    = 1'b0;
      tx_data_d     = tx_data_q;
      tx_data_valid = 1'b0;
      pop           = 1'b0;
    end
  end

  // A write into a full FIFO still lands when the head is popped in the same cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_accept  = bus.wr_en && (!full || pop) && !bus.flush;

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_accept, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (bus.wr_en && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_wait_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_wait_q <= ack_wait_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_data_valid;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a byte-queue model plus a behavioural transmitter that
// answers issue pulses with a busy window (or ignores them), checked every cycle on the falling edge.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: queued bytes, sticky overflow, and the age of an unacknowledged issue pulse.
  byte unsigned modelQ[$];
  bit           modelOverflow;
  int           pendAge;

  // Behavioural transmitter controls.
  int busyLeft;
  bit forcedBusy;
  int acceptPct;
  int rejectNext;
  int frameMin;
  int frameMax;
  int spontPct;

  bit prevValid;
  bit prevBusy;
  int cycleCount;
  int pulseCycles[$];
  byte unsigned pulseData[$];

  bit           armWrite;
  byte unsigned armData;
  bit           armFired;
  bit           checkArmNext;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleCount);
    end
  endtask

  task automatic sampleCycle(input bit we, input byte unsigned d, input bit fl);
    bit v;
    bit busyNow;
    bit pop;
    v       = bus.tx_data_valid;
    busyNow = bus.tx_busy;

    checkOutput("count", bus.count, modelQ.size());
    checkOutput("empty", bus.empty, modelQ.size() == 0);
    checkOutput("full", bus.full, modelQ.size() == DEPTH);
    checkOutput("overflow", bus.overflow, modelOverflow);
    if (v) begin
      checkOutput("valid_nonempty", modelQ.size() > 0, 1);
      if (modelQ.size() > 0) checkOutput("tx_data", bus.tx_data, modelQ[0]);
      checkOutput("pulse_gap", prevValid, 0);
      checkOutput("issue_while_busy", prevBusy, 0);
      checkOutput("issue_in_ack_window", pendAge != 0, 0);
      pulseCycles.push_back(cycleCount);
      pulseData.push_back(bus.tx_data);
    end
    if (checkArmNext) begin
      checkOutput("count_after_full_wr", bus.count, DEPTH);
      checkOutput("ovf_after_full_wr", bus.overflow, 0);
      checkArmNext = 0;
    end
    if (armFired) begin
      checkArmNext = 1;
      armFired     = 0;
    end

    // Busy during the two cycles after a pulse is the acknowledge that retires the head byte.
    pop = (pendAge != 0) && busyNow && !fl;
    if (fl) begin
      modelQ.delete();
      modelOverflow = 0;
      pendAge       = 0;
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (we) begin
        if (modelQ.size() < DEPTH) modelQ.push_back(d);
        else modelOverflow = 1;
      end
    end
    if (pendAge != 0) begin
      if (pop || pendAge == 2) pendAge = 0;
      else pendAge++;
    end
    if (v) pendAge = 1;

    if (v && busyLeft == 0) begin
      if (rejectNext > 0) rejectNext--;
      else if ($urandom_range(99) < acceptPct) busyLeft = $urandom_range(frameMax, frameMin);
    end else if (!v && busyLeft == 0 && pendAge == 0 && $urandom_range(99) < spontPct) begin
      busyLeft = $urandom_range(4, 1);
    end

    prevValid = v;
    prevBusy  = busyNow;
    cycleCount++;
  endtask

  task automatic applyStimulus(input bit we, input byte unsigned d, input bit fl);
    bit busyNext;
    busyNext = forcedBusy || (busyLeft > 0);
    if (busyLeft > 0) busyLeft--;
    if (armWrite && busyNext && !prevBusy && !forcedBusy) begin
      we       = 1;
      d        = armData;
      armWrite = 0;
      armFired = 1;
    end
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.flush   = fl;
    bus.tx_busy = busyNext;
    @(negedge clk);
    sampleCycle(we, d, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0);
  endtask

  task automatic drain(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (modelQ.size() == 0 && busyLeft == 0 && pendAge == 0) break;
      applyStimulus(0, 8'h00, 0);
    end
    checkOutput({"drained_", tag}, bus.count, 0);
  endtask

  task automatic resetDut();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_count", bus.count, 0);
    checkOutput("arst_empty", bus.empty, 1);
    checkOutput("arst_full", bus.full, 0);
    checkOutput("arst_overflow", bus.overflow, 0);
    checkOutput("arst_valid", bus.tx_data_valid, 0);
    checkOutput("arst_tx_data", bus.tx_data, 0);
    modelQ.delete();
    modelOverflow = 0;
    pendAge       = 0;
    busyLeft      = 0;
    prevValid     = 0;
    prevBusy      = 0;
    armWrite      = 0;
    armFired      = 0;
    checkArmNext  = 0;
    bus.wr_en     = 1'b0;
    bus.flush     = 1'b0;
    bus.tx_busy   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int resetAt;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.flush   = 1'b0;
    bus.tx_busy = 1'b0;
    modelOverflow = 0; pendAge = 0; busyLeft = 0; forcedBusy = 0;
    acceptPct = 100; rejectNext = 0; frameMin = 11; frameMax = 11; spontPct = 0;
    prevValid = 0; prevBusy = 0; cycleCount = 0;
    armWrite = 0; armData = 0; armFired = 0; checkArmNext = 0;

    // Reset held for three cycles, then idle with nothing queued.
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_valid", bus.tx_data_valid, 0);
      checkOutput("rst_count", bus.count, 0);
      checkOutput("rst_empty", bus.empty, 1);
    end
    checkOutput("rst_tx_data", bus.tx_data, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(4);

    // Single byte: pulse two cycles after the write.
    pulseCycles.delete(); pulseData.delete();
    w = cycleCount;
    applyStimulus(1, 8'hA5, 0);
    idleCycles(16);
    checkOutput("single_pulses", pulseCycles.size(), 1);
    if (pulseCycles.size() >= 1) begin
      checkOutput("single_latency", pulseCycles[0] - w, 2);
      checkOutput("single_data", pulseData[0], 8'hA5);
    end

    // Burst of 20 into a 16-deep FIFO, then a second run across the pointer wrap.
    pulseData.delete();
    for (int i = 0; i < 20; i++) applyStimulus(1, 8'(i), 0);
    checkOutput("burst_overflow", bus.overflow, 1);
    drain("burst", 600);
    checkOutput("burst_accepted_min", pulseData.size() >= DEPTH, 1);
    for (int k = 0; k < pulseData.size(); k++) checkOutput("burst_order", pulseData[k], k);
    pulseData.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h40 + i), 0);
    drain("wrap", 400);
    checkOutput("wrap_pulses", pulseData.size(), 8);
    for (int k = 0; k < pulseData.size(); k++) checkOutput("wrap_order", pulseData[k], 8'h40 + k);

    applyStimulus(0, 8'h00, 1);
    checkOutput("flush_clears_ovf", bus.overflow, 0);

    // Fill while another source holds busy, then write in the cycle busy rises for the head byte.
    forcedBusy = 1;
    idleCycles(1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h60 + i), 0);
    checkOutput("full_flag", bus.full, 1);
    armWrite = 1; armData = 8'h77; forcedBusy = 0;
    pulseData.delete();
    drain("full", 800);
    checkOutput("full_pulses", pulseData.size(), DEPTH + 1);
    if (pulseData.size() == DEPTH + 1) checkOutput("full_last", pulseData[DEPTH], 8'h77);

    // Transmitter ignores the first pulse; the same byte must come again four cycles later.
    rejectNext = 1;
    pulseCycles.delete(); pulseData.delete();
    applyStimulus(1, 8'h3C, 0);
    drain("reject", 100);
    checkOutput("reject_pulses", pulseCycles.size(), 2);
    if (pulseCycles.size() == 2) begin
      checkOutput("reissue_gap", pulseCycles[1] - pulseCycles[0], 4);
      checkOutput("reissue_data", pulseData[1], 8'h3C);
    end

    // Flush while the first of five bytes is on the line.
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h10 + i), 0);
    idleCycles(2);
    applyStimulus(0, 8'h00, 1);
    checkOutput("flush_count", bus.count, 0);
    checkOutput("flush_ovf", bus.overflow, 0);
    pulseCycles.delete(); pulseData.delete();
    idleCycles(20);
    checkOutput("no_pulse_after_flush", pulseCycles.size(), 0);
    applyStimulus(1, 8'hEE, 1);
    checkOutput("flush_beats_write", bus.count, 0);
    applyStimulus(1, 8'h5A, 0);
    drain("post_flush", 100);
    checkOutput("post_flush_pulses", pulseData.size(), 1);
    if (pulseData.size() == 1) checkOutput("post_flush_data", pulseData[0], 8'h5A);

    // Random traffic with rejects, foreign busy, flushes and one asynchronous reset.
    acceptPct = 80; frameMin = 1; frameMax = 6; spontPct = 3;
    resetAt = $urandom_range(600, 200);
    for (int i = 0; i < 800; i++) begin
      if (i == resetAt) resetDut();
      applyStimulus($urandom_range(99) < 55, 8'($urandom), $urandom_range(99) < 2);
    end
    acceptPct = 100; spontPct = 0;
    drain("random", 3000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and issue controller placed directly upstream of the UART transmitter. It accepts bytes from the system side into a synchronous FIFO. It drains them one at a time into the transmitter using that block's parallel-data, data-valid and busy handshake. It runs in the transmitter's clock domain, so system writes to it must already be in that domain.

Parameters:
DATA_WIDTH, 8, byte width; must match the transmitter width
DEPTH, 16, FIFO entries; power of two, at least 2
ADDR_W, 4, log2(DEPTH); COUNT is ADDR_W+1 bits

Ports:
CLK  in  1  transmitter clock; all logic on the rising edge
RST  in  1  asynchronous active-low reset
WR_DATA  in  DATA_WIDTH  byte to enqueue
WR_EN  in  1  enqueue strobe, one byte per cycle
FLUSH  in  1  synchronous clear of all queued bytes
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
COUNT  out  ADDR_W+1  bytes currently queued, including a byte being issued but not yet accepted
OVERFLOW  out  1  sticky: a write was attempted while FULL; cleared only by RST or FLUSH
TX_DATA  out  DATA_WIDTH  byte presented to the transmitter (P_data)
TX_DATA_VALID  out  1  single-cycle issue pulse to the transmitter
TX_BUSY  in  1  transmitter busy flag

Behaviour:
- Reset (RST low, asynchronous): pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, OVERFLOW = 0, TX_DATA = 0, TX_DATA_VALID = 0, FSM = IDLE. Reset mid-frame discards all queued data; the transmitter is reset separately.
- Write: WR_EN && !FULL stores WR_DATA at the write pointer and increments it, wrapping DEPTH-1 -> 0.
  - WR_EN && FULL drops the byte and sets OVERFLOW.
- FIFO read side:
  - The head byte is popped only when the transmitter acknowledges it (see the FSM).
  - Same-cycle write and pop leaves COUNT unchanged. This is legal when FULL, because the pop frees a slot in the same cycle.
- Issue FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: if !EMPTY && !TX_BUSY, go to ISSUE.
  - ISSUE (1 cycle): TX_DATA = head byte, TX_DATA_VALID = 1, then go to WAIT_ACK. TX_DATA holds its value after the pulse until the next issue.
  - WAIT_ACK: TX_BUSY == 1 acknowledges the byte: pop the head and go to WAIT_DONE.
    - If TX_BUSY is still 0 after 2 cycles in WAIT_ACK, the transmitter rejected the byte: return to IDLE without popping, so the same byte is re-issued.
  - WAIT_DONE: stay while TX_BUSY == 1. On TX_BUSY == 0, go to IDLE.
  - Consequence: at least one idle cycle separates consecutive TX_DATA_VALID pulses.
- Latency: a write into an empty FIFO with the transmitter idle gives TX_DATA_VALID 2 cycles later (write cycle -> IDLE sees !EMPTY -> ISSUE).
- FLUSH:
  - In the flush cycle: pointers and COUNT go to 0, OVERFLOW clears, the FSM returns to IDLE, and TX_DATA_VALID is forced to 0.
  - FLUSH has priority over a same-cycle WR_EN, which is ignored.
  - A byte the transmitter has already accepted still completes on the line.
  - If FLUSH lands in WAIT_DONE, the FSM re-enters IDLE and waits for TX_BUSY == 0 before issuing again.
- Arithmetic:
  - Pointers are ADDR_W bits and wrap naturally.
  - COUNT is a separate ADDR_W+1-bit up/down counter: +1 on accepted write, -1 on pop.
  - FULL and EMPTY decode combinationally from COUNT.
- TX_BUSY high while in IDLE (the transmitter was started by another source): no issue until it falls.

Test Plan:
- Reset then idle: RST low for 3 cycles -> EMPTY = 1, COUNT = 0, TX_DATA_VALID = 0 throughout, no issue while TX_BUSY = 0.
- Single byte: write 0xA5 with the transmitter model idle (busy 1 cycle after valid, for 11 cycles) -> TX_DATA_VALID pulse exactly 1 cycle, 2 cycles after the write, with TX_DATA = 0xA5; COUNT goes 1 -> 0 on the busy rise.
- Burst and wrap: write 0x00..0x13 (20 bytes) back-to-back at DEPTH = 16 -> bytes accepted until FULL, the rest dropped with OVERFLOW = 1; the transmitter receives the accepted bytes in order with no gaps or duplicates. Then write 0x40..0x47 and check order across the pointer wrap.
- Simultaneous write and pop when FULL: in the cycle TX_BUSY rises, WR_EN with 0x77 -> COUNT stays 16, OVERFLOW stays 0, and 0x77 is transmitted last.
- Rejected issue: hold TX_BUSY = 0 for 4 cycles after the pulse -> FSM returns to IDLE, the same byte is re-issued on the next pulse, COUNT unchanged until the busy rise.
- FLUSH mid-frame: queue 5 bytes and flush during WAIT_DONE -> COUNT = 0, OVERFLOW = 0, the current frame finishes, and no further TX_DATA_VALID until a new write. A random RST low mid-burst -> all outputs return to reset values immediately (asynchronous).
